// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_pkg
// Brief    : Shared FSM encoding and timing defaults for the HD44780 bus engines
// Revision : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_ehigh = 3'd2;
    localparam logic [2:0] c_st_elow  = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam int c_t_as_dflt  = 1;
    localparam int c_t_pw_dflt  = 6;
    localparam int c_t_cyc_dflt = 12;

    localparam int c_bf_bit = 7;

endpackage
`default_nettype wire

// File: rtl/hd44780_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_phase_timer
// Brief    : Loadable down-counter; phase_end is high in the last cycle of a phase
// Revision : 1.0 - initial release
// ============================================================================
module hd44780_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] len,
    output logic             phase_end
);

    logic [WIDTH-1:0] r_cnt;

    // Loading len-1 makes a phase of length len end after exactly len cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= len - WIDTH'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign phase_end = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hd44780_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_bus_reader
// Brief    : HD44780 read engine - status/data reads with optional busy polling
// Revision : 1.0 - initial release
// ============================================================================
module hd44780_bus_reader
    import hd44780_pkg::*;
#(
    parameter bit BUS_4BIT   = 1'b0,
    parameter int T_AS       = c_t_as_dflt,
    parameter int T_PW       = c_t_pw_dflt,
    parameter int T_CYC      = c_t_cyc_dflt,
    parameter int POLL_LIMIT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         rs_sel,
    input  logic                         poll_busy,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   rdata,
    output logic                         timeout,
    output logic                         lcd_rs,
    output logic                         lcd_rw,
    output logic                         lcd_e,
    input  logic [(BUS_4BIT ? 4 : 8)-1:0] lcd_db_in
);

    localparam int c_tw = $clog2(T_CYC + 1);
    localparam int c_pw = $clog2(POLL_LIMIT + 2);

    localparam logic [c_tw-1:0] c_len_as = c_tw'(T_AS);
    localparam logic [c_tw-1:0] c_len_pw = c_tw'(T_PW);
    localparam logic [c_tw-1:0] c_len_el = c_tw'(T_CYC - T_AS - T_PW);

    logic [2:0]      r_state;
    logic [2:0]      w_state_pre;
    logic [2:0]      w_state_nxt;
    logic            r_rs_lat;
    logic            r_poll_lat;
    logic            r_nib;
    logic [7:0]      r_cap;
    logic [c_pw-1:0] r_polls;

    logic            w_phase_end;
    logic            w_load;
    logic [c_tw-1:0] w_len;
    logic            w_accept;
    logic            w_cap_strobe;
    logic            w_last_cap;
    logic            w_repeat;

    logic            w_busy_nxt;
    logic            w_e_nxt;
    logic            w_rs_nxt;
    logic            w_done_nxt;

    assign w_accept     = (r_state == c_st_idle) && start;
    assign w_cap_strobe = (r_state == c_st_ehigh) && w_phase_end;
    // In 4-bit mode r_nib=1 marks the low nibble, which completes the byte.
    assign w_last_cap   = w_cap_strobe && (!BUS_4BIT || r_nib);
    assign w_repeat     = r_poll_lat && r_cap[c_bf_bit] &&
                          ((POLL_LIMIT == 0) || (r_polls < c_pw'(POLL_LIMIT)));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_pre = r_state;
        case (r_state)
            c_st_idle:  if (start)       w_state_pre = c_st_setup;
            c_st_setup: if (w_phase_end) w_state_pre = c_st_ehigh;
            c_st_ehigh: if (w_phase_end) w_state_pre = c_st_elow;
            c_st_elow:  if (w_phase_end) w_state_pre = (BUS_4BIT && r_nib) ? c_st_setup : c_st_next;
            c_st_done:                   w_state_pre = c_st_idle;
            default:                     w_state_pre = c_st_idle;
        endcase
    end

    // NEXT is resolved combinationally so it never occupies a clock cycle.
    always_comb begin
        w_state_nxt = w_state_pre;
        if (w_state_pre == c_st_next) begin
            w_state_nxt = w_repeat ? c_st_setup : c_st_done;
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        w_busy_nxt = (w_state_nxt != c_st_idle);
        w_e_nxt    = (w_state_nxt == c_st_ehigh);
        w_done_nxt = (w_state_nxt == c_st_done);
        w_rs_nxt   = w_busy_nxt && (w_accept ? rs_sel : r_rs_lat);
    end

    always_comb begin
        w_load = (w_state_nxt != r_state);
        case (w_state_nxt)
            c_st_ehigh: w_len = c_len_pw;
            c_st_elow:  w_len = c_len_el;
            default:    w_len = c_len_as;
        endcase
    end

    hd44780_phase_timer #(
        .WIDTH (c_tw)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .len       (w_len),
        .phase_end (w_phase_end)
    );

    // ---------------- request latches, nibble index, poll counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_lat   <= 1'b0;
            r_poll_lat <= 1'b0;
            r_nib      <= 1'b0;
            r_polls    <= '0;
        end else begin
            if (w_accept) begin
                r_rs_lat   <= rs_sel;
                r_poll_lat <= poll_busy && !rs_sel;
                r_nib      <= 1'b0;
                r_polls    <= '0;
            end else begin
                if (w_cap_strobe && BUS_4BIT) begin
                    r_nib <= !r_nib;
                end
                if (w_last_cap && (r_polls != '1)) begin
                    r_polls <= r_polls + c_pw'(1);
                end
            end
        end
    end

    // ---------------- capture register ----------------
    generate
        if (BUS_4BIT) begin : g_bus4
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cap <= 8'h00;
                end else if (w_cap_strobe) begin
                    if (!r_nib) begin
                        r_cap[7:4] <= lcd_db_in;
                    end else begin
                        r_cap[3:0] <= lcd_db_in;
                    end
                end
            end
        end else begin : g_bus8
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cap <= 8'h00;
                end else if (w_cap_strobe) begin
                    r_cap <= lcd_db_in;
                end
            end
        end
    endgenerate

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            timeout <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_rw  <= 1'b0;
            lcd_e   <= 1'b0;
        end else begin
            busy   <= w_busy_nxt;
            done   <= w_done_nxt;
            lcd_rs <= w_rs_nxt;
            lcd_rw <= w_busy_nxt;
            lcd_e  <= w_e_nxt;
            if (w_done_nxt) begin
                rdata   <= r_cap;
                timeout <= r_poll_lat && r_cap[c_bf_bit];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hd44780_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd44780_bus_reader
// Brief    : Randomised self-checking bench for three reader configurations
// Revision : 1.0 - initial release
// ============================================================================
module tb_hd44780_bus_reader;

    localparam int c_t_as  = 1;
    localparam int c_t_pw  = 6;
    localparam int c_t_cyc = 12;

    // Instance 0: 8-bit unlimited poll, 1: 4-bit unlimited poll, 2: 8-bit limit 2.
    logic       clk;
    logic       rst;
    logic       start   [3];
    logic       rs_sel  [3];
    logic       poll    [3];
    logic       busy    [3];
    logic       done    [3];
    logic [7:0] rdata   [3];
    logic       timeout [3];
    logic       lcd_rs  [3];
    logic       lcd_rw  [3];
    logic       lcd_e   [3];
    logic [7:0] pad     [3] = '{8'h00, 8'h00, 8'h00};

    logic [7:0] seq [3][8];
    int npulse [3] = '{0, 0, 0};
    int ewbad  [3] = '{0, 0, 0};
    int ecnt   [3] = '{0, 0, 0};
    bit eprev  [3] = '{0, 0, 0};
    int lrise  [3] = '{-1, -1, -1};
    int base   [3] = '{0, 0, 0};
    int cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    hd44780_bus_reader #(.BUS_4BIT(1'b0), .T_AS(c_t_as), .T_PW(c_t_pw), .T_CYC(c_t_cyc), .POLL_LIMIT(0)) u_dut8 (
        .clk(clk), .rst(rst), .start(start[0]), .rs_sel(rs_sel[0]), .poll_busy(poll[0]),
        .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .timeout(timeout[0]),
        .lcd_rs(lcd_rs[0]), .lcd_rw(lcd_rw[0]), .lcd_e(lcd_e[0]), .lcd_db_in(pad[0])
    );

    hd44780_bus_reader #(.BUS_4BIT(1'b1), .T_AS(c_t_as), .T_PW(c_t_pw), .T_CYC(c_t_cyc), .POLL_LIMIT(0)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .rs_sel(rs_sel[1]), .poll_busy(poll[1]),
        .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .timeout(timeout[1]),
        .lcd_rs(lcd_rs[1]), .lcd_rw(lcd_rw[1]), .lcd_e(lcd_e[1]), .lcd_db_in(pad[1][3:0])
    );

    hd44780_bus_reader #(.BUS_4BIT(1'b0), .T_AS(c_t_as), .T_PW(c_t_pw), .T_CYC(c_t_cyc), .POLL_LIMIT(2)) u_dutl (
        .clk(clk), .rst(rst), .start(start[2]), .rs_sel(rs_sel[2]), .poll_busy(poll[2]),
        .busy(busy[2]), .done(done[2]), .rdata(rdata[2]), .timeout(timeout[2]),
        .lcd_rs(lcd_rs[2]), .lcd_rw(lcd_rw[2]), .lcd_e(lcd_e[2]), .lcd_db_in(pad[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pad_val(input int d, input int p);
        int         rd;
        logic [7:0] b;
        rd = (d == 1) ? p / 2 : p;
        if (rd > 7) rd = 7;
        b = seq[d][rd];
        if (d != 1) return b;
        return (p % 2 == 0) ? {4'h0, b[7:4]} : {4'h0, b[3:0]};
    endfunction

    // Pad model: presents the byte/nibble while E is high, junk while E is low,
    // and records E pulse width / spacing violations.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                ecnt[d]  = 0;
                eprev[d] = 1'b0;
                lrise[d] = -1;
            end else begin
                if (lcd_e[d] && !eprev[d]) begin
                    if (lrise[d] >= 0 && cyc - lrise[d] != c_t_cyc) ewbad[d]++;
                    lrise[d] = cyc;
                    npulse[d]++;
                    pad[d] = pad_val(d, npulse[d] - base[d] - 1);
                end
                if (!lcd_e[d] && eprev[d]) begin
                    if (ecnt[d] != c_t_pw) ewbad[d]++;
                    pad[d] = 8'($urandom);
                end
                ecnt[d]  = lcd_e[d] ? ecnt[d] + 1 : 0;
                eprev[d] = lcd_e[d];
                if (!busy[d]) lrise[d] = -1;
            end
        end
    end

    // Reference: reads continue while a polled status shows BF=1 and the limit allows.
    task automatic model(input int d, input bit rs, input bit pl,
                         output int reads, output logic [7:0] rd, output bit to);
        int lim;
        lim   = (d == 2) ? 2 : 0;
        reads = 0;
        do begin
            rd = seq[d][(reads > 7) ? 7 : reads];
            reads++;
        end while (pl && !rs && rd[7] && (lim == 0 || reads < lim));
        to = pl && !rs && rd[7];
    endtask

    task automatic run_txn(input int d, input bit rs, input bit pl);
        int         reads, exp_pulses, exp_lat, w0, n;
        logic [7:0] exp_rd;
        bit         exp_to, seen;
        model(d, rs, pl, reads, exp_rd, exp_to);
        exp_pulses = reads * ((d == 1) ? 2 : 1);
        exp_lat    = 1 + exp_pulses * c_t_cyc;
        @(posedge clk);
        #1;
        check("idle_busy", busy[d], 1'b0);
        check("idle_done", done[d], 1'b0);
        check("idle_rw", lcd_rw[d], 1'b0);
        base[d]   = npulse[d];
        w0        = ewbad[d];
        start[d]  = 1'b1;
        rs_sel[d] = rs;
        poll[d]   = pl;
        seen      = 1'b0;
        for (n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n < 6) begin
                start[d]  = 1'($urandom_range(0, 1));
                rs_sel[d] = 1'($urandom);
                poll[d]   = 1'($urandom);
            end else begin
                start[d] = 1'b0;
            end
            if (done[d]) begin
                seen = 1'b1;
                break;
            end
            check("busy", busy[d], 1'b1);
            check("rw", lcd_rw[d], 1'b1);
            check("rs", lcd_rs[d], rs);
        end
        start[d] = 1'b0;
        check("done_seen", seen, 1'b1);
        check("latency", n, exp_lat);
        check("rdata", rdata[d], exp_rd);
        check("timeout", timeout[d], exp_to);
        check("pulses", npulse[d] - base[d], exp_pulses);
        check("e_timing", ewbad[d] - w0, 0);
    endtask

    initial begin
        bit got [3];
        int n;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start[d]  = 1'b1;
            rs_sel[d] = 1'b1;
            poll[d]   = 1'b0;
            for (int k = 0; k < 8; k++) seq[d][k] = 8'h11;
        end

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", busy[d], 1'b0);
            check("rst_done", done[d], 1'b0);
            check("rst_rdata", rdata[d], 8'h00);
            check("rst_timeout", timeout[d], 1'b0);
            check("rst_e", lcd_e[d], 1'b0);
            check("rst_rs", lcd_rs[d], 1'b0);
            check("rst_rw", lcd_rw[d], 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("post_rst_accept", busy[d], 1'b1);
            start[d] = 1'b0;
            got[d]   = 1'b0;
        end
        for (n = 0; n < 100 && !(got[0] && got[1] && got[2]); n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) if (done[d]) got[d] = 1'b1;
        end
        for (int d = 0; d < 3; d++) check("post_rst_done", got[d], 1'b1);

        // Directed cases
        seq[0][0] = 8'hA5;
        run_txn(0, 1'b1, 1'b0);
        seq[1][0] = 8'h3C;
        run_txn(1, 1'b0, 1'b0);
        seq[0][0] = 8'h80; seq[0][1] = 8'h80; seq[0][2] = 8'h05;
        run_txn(0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) seq[2][k] = 8'h80;
        run_txn(2, 1'b0, 1'b1);

        // Randomised transactions on every configuration
        for (int it = 0; it < 10; it++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 8; k++) begin
                    seq[d][k]    = 8'($urandom);
                    seq[d][k][7] = ($urandom_range(0, 2) != 0);
                end
                seq[d][7][7] = 1'b0;
                run_txn(d, 1'($urandom), 1'($urandom));
            end
        end

        // Reset during E high aborts without done
        seq[0][0] = 8'hA5;
        @(posedge clk);
        #1;
        start[0]  = 1'b1;
        rs_sel[0] = 1'b1;
        poll[0]   = 1'b0;
        for (n = 0; n < 50 && !lcd_e[0]; n++) begin
            @(posedge clk);
            #1;
            start[0] = 1'b0;
        end
        start[0] = 1'b0;
        check("abort_e_seen", lcd_e[0], 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check("abort_e", lcd_e[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        check("abort_rw", lcd_rw[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        got[0] = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done[0] || busy[0]) got[0] = 1'b1;
        end
        check("abort_no_done", got[0], 1'b0);
        check("abort_rdata", rdata[0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
